ram_arbiter: RTL and testbench

- Sole owner of the single-port program/video RAM on clk_ram.
- Shares the RAM between three requesters in fixed priority:
  1. UART program loader (suspends the CPU and writes bytes).
  2. Screen refresher (burst reads).
  3. 6502 CPU (default owner).
- Also sequences CPU halt (RDY) and the post-download CPU reset pulse, so the loader's ask_for_ram / end_of_data pair drives this block, never the CPU directly.

---
 rtl/ram_arb_pkg.sv | 50 +++++
 rtl/ram_arb_fsm.sv | 133 +++++++++++++
 rtl/ram_arbiter.sv | 101 ++++++++++
 tb/tb_ram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared encodings and defaults for the program/video RAM arbiter.
//   - owner codes reported on the owner port
//   - internal arbiter state encoding (adds RESET beside the four owners)
//   - RAM request payload struct used by the address/data mux
//   - default timing parameters
package ram_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OWN_W  = 2;

  localparam logic [OWN_W-1:0] OWN_CPU    = 2'd0;
  localparam logic [OWN_W-1:0] OWN_DRAIN  = 2'd1;
  localparam logic [OWN_W-1:0] OWN_SCREEN = 2'd2;
  localparam logic [OWN_W-1:0] OWN_PROG   = 2'd3;

  localparam int unsigned DEF_SCR_MAX_BURST = 32;
  localparam int unsigned DEF_CPU_MIN_SLOT  = 4;
  localparam int unsigned DEF_RST_CYCLES    = 8;

  typedef enum logic [2:0] {
    ST_CPU    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_SCREEN = 3'd2,
    ST_PROG   = 3'd3,
    ST_RESET  = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

  // RESET is the tail of a download, so it is reported as loader-owned.
  function automatic logic [OWN_W-1:0] state_owner(input arb_state_e s);
    logic [OWN_W-1:0] o;
    o = OWN_CPU;
    case (s)
      ST_CPU:    o = OWN_CPU;
      ST_DRAIN:  o = OWN_DRAIN;
      ST_SCREEN: o = OWN_SCREEN;
      ST_PROG:   o = OWN_PROG;
      ST_RESET:  o = OWN_PROG;
      default:   o = OWN_CPU;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ram_arb_fsm.sv
// ram_arb_fsm: ownership state machine for the shared RAM.
// Holds the state register, screen burst / CPU slot / reset counters, and
// generates the registered cpu_rdy, cpu_rst and owner outputs.
// Ports:
//   clk_ram, reset      clock, async active-low reset
//   prog_req, prog_done loader request and end-of-data
//   scr_req             screen read request
//   state               current arbiter state (drives the RAM mux)
//   owner               registered owner code
//   cpu_rdy, cpu_rst    CPU halt (0 = halted) and active-high CPU reset
//   cpu_stall_cnt       saturating halted-cycle counter (only with ARB_PERF_EN)
module ram_arb_fsm
  import ram_arb_pkg::*;
#(
  parameter int unsigned SCR_MAX_BURST = DEF_SCR_MAX_BURST,
  parameter int unsigned CPU_MIN_SLOT  = DEF_CPU_MIN_SLOT,
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES
) (
  input  logic             clk_ram,
  input  logic             reset,
  input  logic             prog_req,
  input  logic             prog_done,
  input  logic             scr_req,
  output arb_state_e       state,
  output logic [OWN_W-1:0] owner,
  output logic             cpu_rdy,
  output logic             cpu_rst
`ifdef ARB_PERF_EN
  ,
  output logic [15:0]      cpu_stall_cnt
`endif
);

  localparam int unsigned BURST_W = (SCR_MAX_BURST > 1) ? $clog2(SCR_MAX_BURST) : 1;
  localparam int unsigned SLOT_W  = (CPU_MIN_SLOT > 0) ? $clog2(CPU_MIN_SLOT + 1) : 1;
  localparam int unsigned RST_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(SCR_MAX_BURST - 1);
  localparam logic [SLOT_W-1:0]  SLOT_MAX   = SLOT_W'(CPU_MIN_SLOT);
  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RST_CYCLES - 1);

  arb_state_e         state_d;
  logic [BURST_W-1:0] burst_cnt, burst_d;
  logic [SLOT_W-1:0]  slot_cnt, slot_d;
  logic [RST_W-1:0]   rst_cnt, rst_d;
  logic               prog_req_q;
  logic               prog_rise;
  logic               slot_ok;
  logic [OWN_W-1:0]   owner_d;
  logic               rdy_d;
  logic               crst_d;

  // Next state, counter next values and registered-output next values
  always_comb begin
    state_d   = state;
    burst_d   = '0;
    slot_d    = slot_cnt;
    rst_d     = '0;
    prog_rise = prog_req & ~prog_req_q;
    // slot_cnt counts CPU cycles already served; this cycle completes the
    // minimum slot when it is the CPU_MIN_SLOT-th one.
    slot_ok   = (({1'b0, slot_cnt} + (SLOT_W + 1)'(1)) >= (SLOT_W + 1)'(CPU_MIN_SLOT));

    case (state)
      ST_CPU: begin
        if (prog_req || (scr_req && slot_ok)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (prog_req)     state_d = ST_PROG;
        else if (scr_req) state_d = ST_SCREEN;
        else              state_d = ST_CPU;
      end
      ST_SCREEN: begin
        if (prog_req)                                state_d = ST_PROG;
        else if (!scr_req || burst_cnt == BURST_LAST) state_d = ST_CPU;
      end
      ST_PROG: begin
        if (prog_done)     state_d = ST_RESET;
        else if (!prog_req) state_d = ST_CPU;
      end
      ST_RESET: begin
        if (prog_rise)              state_d = ST_PROG;
        else if (rst_cnt == RST_LAST) state_d = ST_CPU;
      end
      default: state_d = ST_CPU;
    endcase

    if (state == ST_SCREEN && state_d == ST_SCREEN) burst_d = burst_cnt + BURST_W'(1);
    if (state == ST_RESET && state_d == ST_RESET)   rst_d   = rst_cnt + RST_W'(1);

    if (state == ST_SCREEN && state_d != ST_SCREEN)   slot_d = '0;
    else if (state == ST_CPU && slot_cnt != SLOT_MAX) slot_d = slot_cnt + SLOT_W'(1);

    owner_d = state_owner(state_d);
    rdy_d   = (state_d == ST_CPU);
    crst_d  = (state_d == ST_RESET);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_ram or negedge reset) begin
    if (!reset) begin
      state      <= ST_CPU;
      burst_cnt  <= '0;
      slot_cnt   <= '0;
      rst_cnt    <= '0;
      prog_req_q <= 1'b0;
      owner      <= OWN_CPU;
      cpu_rdy    <= 1'b1;
      cpu_rst    <= 1'b0;
    end else begin
      state      <= state_d;
      burst_cnt  <= burst_d;
      slot_cnt   <= slot_d;
      rst_cnt    <= rst_d;
      prog_req_q <= prog_req;
      owner      <= owner_d;
      cpu_rdy    <= rdy_d;
      cpu_rst    <= crst_d;
    end
  end

`ifdef ARB_PERF_EN
  // Cycles the CPU is halted outside its reset pulse, saturating
  always_ff @(posedge clk_ram or negedge reset) begin
    if (!reset) begin
      cpu_stall_cnt <= '0;
    end else if (!cpu_rdy && !cpu_rst && cpu_stall_cnt != 16'hFFFF) begin
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: sole owner of the single-port program/video RAM.
// Priority: UART loader > screen refresher > 6502 CPU (default owner).
// Also sequences CPU halt (cpu_rdy) and the post-download cpu_rst pulse.
// Optional build macro ARB_PERF_EN adds the cpu_stall_cnt output.
// Ports:
//   clk_ram, reset                      clock, async active-low reset
//   prog_req/done/we/addr/wdata         loader interface
//   scr_req/addr, scr_gnt/rvalid/rdata  screen read interface
//   cpu_addr/we/wdata, cpu_rdata        CPU bus
//   cpu_rdy, cpu_rst                    CPU halt / reset control
//   ram_addr/we/wdata, ram_rdata        RAM port (1-cycle read latency)
//   owner                               0 CPU, 1 DRAIN, 2 SCREEN, 3 PROG
//   cpu_stall_cnt                       halted-cycle counter (ARB_PERF_EN)
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned SCR_MAX_BURST = DEF_SCR_MAX_BURST,
  parameter int unsigned CPU_MIN_SLOT  = DEF_CPU_MIN_SLOT,
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES
) (
  input  logic        clk_ram,
  input  logic        reset,
  input  logic        prog_req,
  input  logic        prog_done,
  input  logic        prog_we,
  input  logic [15:0] prog_addr,
  input  logic [7:0]  prog_wdata,
  input  logic        scr_req,
  input  logic [15:0] scr_addr,
  output logic        scr_gnt,
  output logic        scr_rvalid,
  output logic [7:0]  scr_rdata,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic        cpu_rst,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [1:0]  owner
`ifdef ARB_PERF_EN
  ,
  output logic [15:0] cpu_stall_cnt
`endif
);

  arb_state_e state;
  ram_req_t   ram_req;

  ram_arb_fsm #(
    .SCR_MAX_BURST (SCR_MAX_BURST),
    .CPU_MIN_SLOT  (CPU_MIN_SLOT),
    .RST_CYCLES    (RST_CYCLES)
  ) u_fsm (
    .clk_ram   (clk_ram),
    .reset     (reset),
    .prog_req  (prog_req),
    .prog_done (prog_done),
    .scr_req   (scr_req),
    .state     (state),
    .owner     (owner),
    .cpu_rdy   (cpu_rdy),
    .cpu_rst   (cpu_rst)
`ifdef ARB_PERF_EN
    ,
    .cpu_stall_cnt (cpu_stall_cnt)
`endif
  );

  // RAM port mux selected by the registered state; DRAIN lets the CPU's
  // in-flight access finish, RESET keeps the CPU address but blocks writes.
  always_comb begin
    ram_req = '{addr: cpu_addr, we: cpu_we, wdata: cpu_wdata};
    case (state)
      ST_SCREEN: ram_req = '{addr: scr_addr, we: 1'b0, wdata: cpu_wdata};
      ST_PROG:   ram_req = '{addr: prog_addr, we: prog_we, wdata: prog_wdata};
      ST_RESET:  ram_req.we = 1'b0;
      default:   ;
    endcase
  end

  assign ram_addr  = ram_req.addr;
  assign ram_we    = ram_req.we & reset;
  assign ram_wdata = ram_req.wdata;

  // Loader pre-empts the screen in the same cycle; the screen retries later.
  assign scr_gnt   = (state == ST_SCREEN) & scr_req & ~prog_req;

  assign cpu_rdata = ram_rdata;
  assign scr_rdata = ram_rdata;

  // Read data returns one cycle after the grant
  always_ff @(posedge clk_ram or negedge reset) begin
    if (!reset) scr_rvalid <= 1'b0;
    else        scr_rvalid <= scr_gnt & scr_req;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural RAM and a
// screen-read scoreboard (expected byte queued at grant, checked at rvalid).
module tb_ram_arbiter;

  logic        clk_ram = 1'b0;
  logic        reset   = 1'b1;
  logic        prog_req, prog_done, prog_we;
  logic [15:0] prog_addr;
  logic [7:0]  prog_wdata;
  logic        scr_req;
  logic [15:0] scr_addr;
  logic        scr_gnt, scr_rvalid;
  logic [7:0]  scr_rdata;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy, cpu_rst;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [1:0]  owner;
`ifdef ARB_PERF_EN
  logic [15:0] cpu_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       prev_gnt = 1'b0;
  logic [7:0] mem [0:65535];
  bit         mem_loaded = 1'b0;

  ram_arbiter dut (
    .clk_ram    (clk_ram),
    .reset      (reset),
    .prog_req   (prog_req),
    .prog_done  (prog_done),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .scr_req    (scr_req),
    .scr_addr   (scr_addr),
    .scr_gnt    (scr_gnt),
    .scr_rvalid (scr_rvalid),
    .scr_rdata  (scr_rdata),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rdy    (cpu_rdy),
    .cpu_rst    (cpu_rst),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .owner      (owner)
`ifdef ARB_PERF_EN
    ,
    .cpu_stall_cnt (cpu_stall_cnt)
`endif
  );

  always #5 clk_ram = ~clk_ram;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Behavioural single-port RAM, registered read, read-before-write
  always @(posedge clk_ram) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
      mem_loaded = 1'b1;
    end
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_ram);
    #1;
  endtask

  // Screen scoreboard and rvalid-lag monitor
  always @(negedge clk_ram) begin
    if (reset && mem_loaded) begin
      check("rvalid_lag", 32'(scr_rvalid), 32'(prev_gnt));
      if (scr_rvalid) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("scr_rdata", 32'(scr_rdata), 32'(exp_q.pop_front()));
      end
      if (scr_gnt) exp_q.push_back(mem[scr_addr]);
    end
    prev_gnt = scr_gnt & reset;
  end

  function automatic int burst_owner(input int i);
    if (i == 0) return 0;
    if (i == 1) return 1;
    if (i <= 33) return 2;
    if (i <= 37) return 0;
    if (i == 38) return 1;
    return 2;
  endfunction

  logic [7:0] dl_bytes [0:2];
  bit found;

  initial begin
    dl_bytes[0] = 8'h11; dl_bytes[1] = 8'h22; dl_bytes[2] = 8'h33;
    prog_req = 0; prog_done = 0; prog_we = 0; prog_addr = '0; prog_wdata = '0;
    scr_req = 0; scr_addr = '0;
    cpu_addr = 16'h0100; cpu_we = 1'b1; cpu_wdata = 8'h00;

    // Reset values
    #1 reset = 1'b0;
    #1;
    check("rst_owner", 32'(owner), 0);
    check("rst_rdy", 32'(cpu_rdy), 1);
    check("rst_cpurst", 32'(cpu_rst), 0);
    check("rst_gnt", 32'(scr_gnt), 0);
    check("rst_rvalid", 32'(scr_rvalid), 0);
    check("rst_ram_we", 32'(ram_we), 0);
`ifdef ARB_PERF_EN
    check("rst_stall", 32'(cpu_stall_cnt), 0);
`endif
    step();
    reset = 1'b1;
    cpu_we = 1'b0;

    // Idle, then a CPU write
    repeat (20) step();
    #1;
    check("idle_owner", 32'(owner), 0);
    check("idle_rdy", 32'(cpu_rdy), 1);
    cpu_addr = 16'h0200; cpu_wdata = 8'h5A; cpu_we = 1'b1;
    #1;
    check("cpu_wr_we", 32'(ram_we), 1);
    check("cpu_wr_addr", 32'(ram_addr), 'h0200);
    step();
    cpu_we = 1'b0; cpu_addr = 16'h0100;
    #1;
    check("cpu_wr_mem", 32'(mem[16'h0200]), 'h5A);

    // Screen held for 40 cycles: DRAIN, 32 grants, 4 CPU, DRAIN, SCREEN
    for (int i = 0; i < 40; i++) begin
      step();
      scr_req = 1'b1;
      scr_addr = 16'h1000 + 16'(i);
      #1;
      check($sformatf("burst_own[%0d]", i), 32'(owner), 32'(burst_owner(i)));
      check($sformatf("burst_gnt[%0d]", i), 32'(scr_gnt), 32'(burst_owner(i) == 2));
      if (i == 1 || i == 20) check($sformatf("burst_rdy[%0d]", i), 32'(cpu_rdy), 0);
      if (i == 35) check("slot_rdy", 32'(cpu_rdy), 1);
    end
    step();
    scr_req = 1'b0;
    #1;
    check("scr_drop_own", 32'(owner), 2);
    check("scr_drop_gnt", 32'(scr_gnt), 0);
    step();
    #1;
    check("scr_drop_cpu", 32'(owner), 0);

    // Loader pre-empts a screen burst
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      scr_req = 1'b1;
      scr_addr = 16'h2000 + 16'(k);
      #1;
      if (owner == 2'd2) found = 1'b1;
    end
    check("t3_reach_screen", 32'(found), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      scr_addr = 16'h2100 + 16'(k);
      #1;
      check("t3_gnt", 32'(scr_gnt), 1);
    end
    step();
    prog_req = 1'b1; prog_we = 1'b1; prog_addr = 16'h0600; prog_wdata = 8'hA9;
    #1;
    check("preempt_gnt", 32'(scr_gnt), 0);
    check("preempt_own", 32'(owner), 2);
    step();
    scr_req = 1'b0;
    #1;
    check("prog_own", 32'(owner), 3);
    check("prog_rdy", 32'(cpu_rdy), 0);
    check("prog_we", 32'(ram_we), 1);
    check("prog_addr", 32'(ram_addr), 'h0600);

    // Three-byte download then end-of-data
    for (int b = 0; b < 3; b++) begin
      step();
      prog_addr = 16'h0700 + 16'(b);
      prog_wdata = dl_bytes[b];
      #1;
      check("dl_own", 32'(owner), 3);
    end
    step();
    prog_we = 1'b0; prog_done = 1'b1; prog_req = 1'b0;
    #1;
    check("done_own", 32'(owner), 3);
    check("mem_0600", 32'(mem[16'h0600]), 'hA9);
    for (int b = 0; b < 3; b++)
      check("mem_dl", 32'(mem[16'h0700 + 16'(b)]), 32'(dl_bytes[b]));
    for (int r = 0; r < 8; r++) begin
      step();
      prog_done = 1'b0;
      cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'hEE;
      #1;
      check($sformatf("rstseq_rst[%0d]", r), 32'(cpu_rst), 1);
      check($sformatf("rstseq_rdy[%0d]", r), 32'(cpu_rdy), 0);
      check("rstseq_we", 32'(ram_we), 0);
    end
    step();
    cpu_we = 1'b0; cpu_addr = 16'h0100;
    #1;
    check("rstend_rst", 32'(cpu_rst), 0);
    check("rstend_own", 32'(owner), 0);
    check("rstend_rdy", 32'(cpu_rdy), 1);
    check("mem_0300", 32'(mem[16'h0300]), 32'(pat(16'h0300)));

    // prog_req and scr_req together: loader wins, screen waits for reset end
    step();
    prog_req = 1'b1; scr_req = 1'b1; scr_addr = 16'h3000;
    #1;
    check("both_own0", 32'(owner), 0);
    step(); #1;
    check("both_drain", 32'(owner), 1);
    check("both_gnt_d", 32'(scr_gnt), 0);
    step(); #1;
    check("both_prog", 32'(owner), 3);
    check("both_gnt_p", 32'(scr_gnt), 0);
    step();
    prog_req = 1'b0; prog_done = 1'b1;
    #1;
    check("both_gnt_done", 32'(scr_gnt), 0);
    for (int r = 0; r < 8; r++) begin
      step();
      prog_done = 1'b0;
      #1;
      check("both_rst", 32'(cpu_rst), 1);
      check("both_gnt_r", 32'(scr_gnt), 0);
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(); #1;
      if (scr_gnt) found = 1'b1;
    end
    check("both_gnt_after", 32'(found), 1);
    check("both_own_scr", 32'(owner), 2);
    step();
    scr_req = 1'b0;
    step(); #1;
    check("both_back_cpu", 32'(owner), 0);

    // prog_req rising during RESET returns to PROG; count restarts
    step(); prog_req = 1'b1;
    step();
    step(); #1;
    check("t6_prog", 32'(owner), 3);
    step(); prog_req = 1'b0; prog_done = 1'b1;
    step(); prog_done = 1'b0; #1;
    check("t6_rst1", 32'(cpu_rst), 1);
    step();
    step();
    step(); prog_req = 1'b1; #1;
    check("t6_rst4", 32'(cpu_rst), 1);
    step(); #1;
    check("t6_reprog_own", 32'(owner), 3);
    check("t6_reprog_rst", 32'(cpu_rst), 0);
    check("t6_reprog_rdy", 32'(cpu_rdy), 0);
    step(); prog_req = 1'b0; prog_done = 1'b1;
    for (int r = 0; r < 8; r++) begin
      step();
      prog_done = 1'b0;
      #1;
      check($sformatf("t6_restart[%0d]", r), 32'(cpu_rst), 1);
    end
    step(); #1;
    check("t6_end_rst", 32'(cpu_rst), 0);
    check("t6_end_own", 32'(owner), 0);

    // Async reset while in RESET
    step(); prog_req = 1'b1;
    step();
    step();
    step(); prog_req = 1'b0; prog_done = 1'b1;
    step(); prog_done = 1'b0;
    step(); #1;
    check("ar_pre_rst", 32'(cpu_rst), 1);
    check("ar_pre_own", 32'(owner), 3);
    reset = 1'b0;
    #1;
    check("ar_rst", 32'(cpu_rst), 0);
    check("ar_own", 32'(owner), 0);
    check("ar_rdy", 32'(cpu_rdy), 1);
    check("ar_gnt", 32'(scr_gnt), 0);
    check("ar_rvalid", 32'(scr_rvalid), 0);
    check("ar_we", 32'(ram_we), 0);
`ifdef ARB_PERF_EN
    check("ar_stall", 32'(cpu_stall_cnt), 0);
`endif
    step();
    reset = 1'b1;
    step(); #1;
    check("post_own", 32'(owner), 0);
    check("post_rdy", 32'(cpu_rdy), 1);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
